// File: rtl/msrv32_instr_buffer.sv
// -----------------------------------------------------------------------------
// msrv32_instr_buffer
//
// Purpose:
//   Instruction buffer between the instruction-memory response and the decode
//   stage. It holds up to DEPTH fetched instructions together with their PCs.
//   Both sides use a valid/ready handshake. The head entry is split into the
//   decode fields: opcode, funct3/funct7, rs1/rs2/rd, CSR address and the
//   immediate source bits [31:7].
//
//   When the buffer is empty, or while flush_in is high, the field outputs show
//   NOP_INSTR and pc_out is 0. A flush empties the buffer in one cycle. A
//   saturating counter adds up how many entries the flushes have thrown away.
//
// Ports:
//   ms_riscv32_mp_clk_in    clock; all state changes on its rising edge
//   ms_riscv32_mp_rst_in    asynchronous reset, active low
//   flush_in                drop every queued entry; blocks this cycle's write
//   instr_valid_in          fetch side: instruction and PC are valid
//   ms_riscv32_mp_instr_in  fetched instruction
//   pc_in                   PC of the fetched instruction
//   instr_ready_out         buffer accepts a write this cycle
//   dec_valid_out           head entry is presented to decode
//   dec_ready_in            decode consumes the head entry
//   opcode_out .. instr_out decode fields of the selected instruction
//   pc_out                  PC of the head entry, or 0 when NOP is shown
//   count_out               number of occupied entries
//   drop_count_out          saturating total of entries discarded by flushes
// -----------------------------------------------------------------------------
module msrv32_instr_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned DROP_W    = 8
) (
    input  logic                       ms_riscv32_mp_clk_in,
    input  logic                       ms_riscv32_mp_rst_in,
    input  logic                       flush_in,
    input  logic                       instr_valid_in,
    input  logic [31:0]                ms_riscv32_mp_instr_in,
    input  logic [31:0]                pc_in,
    output logic                       instr_ready_out,
    output logic                       dec_valid_out,
    input  logic                       dec_ready_in,
    output logic [6:0]                 opcode_out,
    output logic [2:0]                 funct3_out,
    output logic [6:0]                 funct7_out,
    output logic [4:0]                 rs1addr_out,
    output logic [4:0]                 rs2addr_out,
    output logic [4:0]                 rdaddr_out,
    output logic [11:0]                csr_addr_out,
    output logic [24:0]                instr_out,
    output logic [31:0]                pc_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic [DROP_W-1:0]          drop_count_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // The sum is made wide enough that adding the count can never wrap
    // before the saturation compare.
    localparam int unsigned SW = ((DROP_W > CW) ? DROP_W : CW) + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] DROP_MAX = SW'({DROP_W{1'b1}});

    // -------------------------------------------------------------------------
    // Storage and control state
    // -------------------------------------------------------------------------
    logic [31:0]       r_instr_mem [DEPTH];
    logic [31:0]       r_pc_mem    [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_ready;
    logic              w_valid;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_sel_nop;
    logic [31:0]       w_sel_instr;
    logic [31:0]       w_sel_pc;
    logic [SW-1:0]     w_drop_sum;
    logic [DROP_W-1:0] w_drop_next;
    logic [CW-1:0]     w_count_next;

    // -------------------------------------------------------------------------
    // Handshake. Ready looks only at occupancy, never at dec_ready_in. So a
    // full buffer refuses a write even in a cycle where it is also being read.
    // This keeps ready free of any combinational path from the decode side.
    // -------------------------------------------------------------------------
    assign w_ready = !flush_in && (r_count != FULL_CNT);
    assign w_valid = !flush_in && (r_count != '0);
    assign w_wr_en = instr_valid_in && w_ready;
    assign w_rd_en = w_valid && dec_ready_in;

    assign instr_ready_out = w_ready;
    assign dec_valid_out   = w_valid;
    assign count_out       = r_count;
    assign drop_count_out  = r_drop_cnt;

    // -------------------------------------------------------------------------
    // Head selection. NOP is shown when the buffer is empty or being flushed,
    // so decode never sees stale array contents.
    // -------------------------------------------------------------------------
    assign w_sel_nop   = flush_in || (r_count == '0);
    assign w_sel_instr = w_sel_nop ? NOP_INSTR : r_instr_mem[r_rd_ptr];
    assign w_sel_pc    = w_sel_nop ? 32'h0    : r_pc_mem[r_rd_ptr];

    assign opcode_out   = w_sel_instr[6:0];
    assign funct3_out   = w_sel_instr[14:12];
    assign funct7_out   = w_sel_instr[31:25];
    assign rs1addr_out  = w_sel_instr[19:15];
    assign rs2addr_out  = w_sel_instr[24:20];
    assign rdaddr_out   = w_sel_instr[11:7];
    assign csr_addr_out = w_sel_instr[31:20];
    assign instr_out    = w_sel_instr[31:7];
    assign pc_out       = w_sel_pc;

    // -------------------------------------------------------------------------
    // Next-state values for the occupancy and drop counters
    // -------------------------------------------------------------------------
    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr_en, w_rd_en})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;   // idle, or a read and write together
        endcase
    end

    assign w_drop_sum  = SW'(r_drop_cnt) + SW'(r_count);
    assign w_drop_next = (w_drop_sum > DROP_MAX) ? DROP_MAX[DROP_W-1:0]
                                                 : w_drop_sum[DROP_W-1:0];

    // -------------------------------------------------------------------------
    // Array write. The data array has no reset. Only the pointers and the
    // count decide which entries are live.
    // -------------------------------------------------------------------------
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (w_wr_en) begin
            r_instr_mem[r_wr_ptr] <= ms_riscv32_mp_instr_in;
            r_pc_mem[r_wr_ptr]    <= pc_in;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy and drop counter. The pointers are AW bits wide, so
    // they wrap from DEPTH-1 to 0 without extra logic (DEPTH is a power of 2).
    // A flush adds the pre-flush count to the drop total. An empty flush adds 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else if (flush_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= w_drop_next;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

endmodule
